// File: rtl/program_ram_loader.sv
// Writable program memory for the mini-CPU. A registered fetch port serves the CPU and a
// byte-stream loader fills the memory through a valid/ready handshake.
`ifndef NOP
`define NOP 4'hF
`endif
`ifndef LED
`define LED 4'h9
`endif

module program_ram_loader #(
    parameter int unsigned           DATA_WIDTH   = 28,
    parameter int unsigned           ADDR_WIDTH   = 8,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD     = {`NOP, 24'd0},
    parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = {`LED, 24'b10101010}
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [15:0]           iAddress,
    output logic [DATA_WIDTH-1:0] oInstruction,
    input  logic                  iLoadEnable,
    input  logic [7:0]            iByte,
    input  logic                  iByteValid,
    output logic                  oByteReady,
    output logic                  oBusy,
    output logic                  oLoadFull,
    output logic [ADDR_WIDTH:0]   oWordCount
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned BPW   = (DATA_WIDTH + 7) / 8;
    localparam int unsigned BCW   = $clog2(BPW + 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [BCW-1:0]      LAST_BYTE = BCW'(BPW - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        FULL
    } state_t;

    state_t                  state;
    logic                    ready_q;
    logic                    busy_q;
    logic                    full_q;
    logic [ADDR_WIDTH-1:0]   wptr;
    logic [BCW-1:0]          bcnt;
    logic [ADDR_WIDTH:0]     wcount;
    logic [DATA_WIDTH-1:0]   assembly;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            full_q   <= 1'b0;
            wptr     <= '0;
            bcnt     <= '0;
            wcount   <= '0;
            assembly <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (iLoadEnable) begin
                        state   <= LOAD;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                        wptr    <= '0;
                        bcnt    <= '0;
                        wcount  <= '0;
                    end
                end
                LOAD: begin
                    if (!iLoadEnable) begin
                        state   <= IDLE;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (iByteValid) begin
                        // Truncating cast drops the surplus high bits of the first byte.
                        assembly <= DATA_WIDTH'({assembly, iByte});
                        if (bcnt == LAST_BYTE) begin
                            state   <= WRITE;
                            ready_q <= 1'b0;
                        end else begin
                            bcnt <= bcnt + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    wptr   <= wptr + 1'b1;
                    wcount <= wcount + 1'b1;
                    bcnt   <= '0;
                    if (!iLoadEnable) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (wcount == DEPTH_CNT - 1'b1) begin
                        state  <= FULL;
                        full_q <= 1'b1;
                    end else begin
                        state   <= LOAD;
                        ready_q <= 1'b1;
                    end
                end
                FULL: begin
                    if (!iLoadEnable) begin
                        state  <= IDLE;
                        full_q <= 1'b0;
                        busy_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory is deliberately not reset; contents survive Reset.
    always_ff @(posedge Clock) begin
        if (state == WRITE) begin
            mem[wptr] <= assembly;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            oInstruction <= NOP_WORD;
        end else if (state != IDLE) begin
            oInstruction <= NOP_WORD;
        end else if (32'(iAddress) < DEPTH) begin
            oInstruction <= mem[iAddress[ADDR_WIDTH-1:0]];
        end else begin
            oInstruction <= DEFAULT_WORD;
        end
    end

    assign oByteReady = ready_q & iLoadEnable;
    assign oBusy      = busy_q;
    assign oLoadFull  = full_q;
    assign oWordCount = wcount;

endmodule

// File: tb/tb_program_ram_loader.sv
// Directed bench for program_ram_loader: a default-size instance plus a 4-word instance
// used for the full-memory scenario.
module tb_program_ram_loader;

    localparam logic [27:0] NOP_W = 28'hF000000;
    localparam logic [27:0] DEF_W = 28'h90000AA;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] addr = '0;
    logic        en = 1'b0;
    logic        sel = 1'b0;
    logic [7:0]  byte_d = '0;
    logic        valid = 1'b0;

    logic [27:0] instr_a, instr_b, instr;
    logic        rdy_a, rdy_b, rdy;
    logic        busy_a, busy_b, busy;
    logic        full_a, full_b, full;
    logic [8:0]  wc_a;
    logic [2:0]  wc_b;
    logic        en_a, en_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign en_a  = en & ~sel;
    assign en_b  = en & sel;
    assign instr = sel ? instr_b : instr_a;
    assign rdy   = sel ? rdy_b : rdy_a;
    assign busy  = sel ? busy_b : busy_a;
    assign full  = sel ? full_b : full_a;

    program_ram_loader u_big (
        .Clock(clk), .Reset(rst_n), .iAddress(addr), .oInstruction(instr_a),
        .iLoadEnable(en_a), .iByte(byte_d), .iByteValid(valid), .oByteReady(rdy_a),
        .oBusy(busy_a), .oLoadFull(full_a), .oWordCount(wc_a)
    );

    program_ram_loader #(.ADDR_WIDTH(2)) u_small (
        .Clock(clk), .Reset(rst_n), .iAddress(addr), .oInstruction(instr_b),
        .iLoadEnable(en_b), .iByte(byte_d), .iByteValid(valid), .oByteReady(rdy_b),
        .oBusy(busy_b), .oLoadFull(full_b), .oWordCount(wc_b)
    );

    // Present one byte until the loader is ready; returns at the negedge after acceptance.
    task automatic send_byte(input logic [7:0] b, output logic ok);
        byte_d = b;
        valid  = 1'b1;
        ok     = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            #1;
            if (rdy === 1'b1) ok = 1'b1;
            @(negedge clk);
        end
        valid = 1'b0;
    endtask

    // Stream one word MSB first; reports handshake success and ready during the WRITE cycle.
    task automatic send_word(input logic [31:0] w, input bit gaps, output logic ok,
                             output logic wr_rdy);
        logic bok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            send_byte(w[31-8*i -: 8], bok);
            ok = ok & bok;
        end
        #1;
        wr_rdy = rdy;
    endtask

    task automatic do_fetch(input logic [15:0] a, output logic [27:0] d);
        addr = a;
        @(negedge clk);
        d = instr;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if (instr_a !== NOP_W || rdy_a !== 1'b0 || busy_a !== 1'b0 || full_a !== 1'b0 ||
            wc_a !== 9'd0) begin
            errors++;
            $display("FAIL reset_state: instr=%h rdy=%b busy=%b full=%b wc=%0d, want %h 0 0 0 0",
                     instr_a, rdy_a, busy_a, full_a, wc_a, NOP_W);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_load;
        logic ok, wr;
        logic [27:0] d;
        logic [31:0] words [2] = '{32'h01234567, 32'h0FEDCBA9};
        addr = 16'd0;
        en = 1'b1;
        #1;
        checks++;
        if (rdy !== 1'b0) begin
            errors++;
            $display("FAIL ready_latency: rdy=%b in first cycle, want 0", rdy);
        end
        for (int i = 0; i < 2; i++) begin
            send_word(words[i], 1'b0, ok, wr);
            checks++;
            if (ok !== 1'b1 || wr !== 1'b0) begin
                errors++;
                $display("FAIL basic_word%0d: accepted=%b write_rdy=%b, want 1 0", i, ok, wr);
            end
        end
        checks++;
        if (instr !== NOP_W) begin
            errors++;
            $display("FAIL busy_fetch: instr=%h, want %h", instr, NOP_W);
        end
        en = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || wc_a !== 9'd2) begin
            errors++;
            $display("FAIL basic_count: busy=%b wc=%0d, want 0 2", busy, wc_a);
        end
        do_fetch(16'd0, d);
        checks++;
        if (d !== 28'h1234567) begin
            errors++;
            $display("FAIL basic_fetch0: got %h, want 1234567", d);
        end
        do_fetch(16'd1, d);
        checks++;
        if (d !== 28'hFEDCBA9) begin
            errors++;
            $display("FAIL basic_fetch1: got %h, want fedcba9", d);
        end
    endtask

    task automatic test_gaps;
        logic ok, wr;
        logic [27:0] d;
        logic [31:0] words [3] = '{32'hA1112233, 32'h0C0FFEE0, 32'h0DEADBEE};
        logic [27:0] exp   [3] = '{28'h1112233, 28'hC0FFEE0, 28'hDEADBEE};
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_word(words[i], 1'b1, ok, wr);
            checks++;
            if (ok !== 1'b1 || wr !== 1'b0) begin
                errors++;
                $display("FAIL gap_word%0d: accepted=%b write_rdy=%b, want 1 0", i, ok, wr);
            end
        end
        en = 1'b0;
        @(negedge clk);
        checks++;
        if (wc_a !== 9'd3) begin
            errors++;
            $display("FAIL gap_count: wc=%0d, want 3", wc_a);
        end
        for (int i = 0; i < 3; i++) begin
            do_fetch(16'(i), d);
            checks++;
            if (d !== exp[i]) begin
                errors++;
                $display("FAIL gap_fetch%0d: got %h, want %h", i, d, exp[i]);
            end
        end
    endtask

    task automatic test_abort;
        logic ok, wr, b1, b2;
        logic [27:0] d;
        logic [27:0] exp [3] = '{28'h7654321, 28'hC0FFEE0, 28'hDEADBEE};
        en = 1'b1;
        send_word(32'h07654321, 1'b0, ok, wr);
        send_byte(8'h05, b1);
        send_byte(8'h55, b2);
        checks++;
        if ((ok & b1 & b2) !== 1'b1 || wr !== 1'b0) begin
            errors++;
            $display("FAIL abort_stim: accepted=%b write_rdy=%b, want 1 0", ok & b1 & b2, wr);
        end
        en = 1'b0;
        byte_d = 8'hAA;
        valid = 1'b1;
        #1;
        checks++;
        if (rdy !== 1'b0) begin
            errors++;
            $display("FAIL abort_ready: rdy=%b with enable low, want 0", rdy);
        end
        @(negedge clk);
        valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || wc_a !== 9'd1) begin
            errors++;
            $display("FAIL abort_count: busy=%b wc=%0d, want 0 1", busy, wc_a);
        end
        for (int i = 0; i < 3; i++) begin
            do_fetch(16'(i), d);
            checks++;
            if (d !== exp[i]) begin
                errors++;
                $display("FAIL abort_fetch%0d: got %h, want %h", i, d, exp[i]);
            end
        end
    endtask

    task automatic test_reset_midload;
        logic b1, b2;
        logic [27:0] d;
        en = 1'b1;
        send_byte(8'h01, b1);
        send_byte(8'h02, b2);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (instr_a !== NOP_W || rdy_a !== 1'b0 || busy_a !== 1'b0 || wc_a !== 9'd0) begin
            errors++;
            $display("FAIL midload_reset: instr=%h rdy=%b busy=%b wc=%0d, want %h 0 0 0",
                     instr_a, rdy_a, busy_a, wc_a, NOP_W);
        end
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_fetch(16'd0, d);
        checks++;
        if (d !== 28'h7654321 || wc_a !== 9'd0) begin
            errors++;
            $display("FAIL reset_retain: got %h wc=%0d, want 7654321 0", d, wc_a);
        end
    endtask

    task automatic test_range;
        logic [27:0] d;
        do_fetch(16'd256, d);
        checks++;
        if (d !== DEF_W) begin
            errors++;
            $display("FAIL range_256: got %h, want %h", d, DEF_W);
        end
        do_fetch(16'hFFFF, d);
        checks++;
        if (d !== DEF_W) begin
            errors++;
            $display("FAIL range_ffff: got %h, want %h", d, DEF_W);
        end
    endtask

    task automatic test_full;
        logic ok, wr;
        logic [27:0] d;
        logic [31:0] words [4] = '{32'h0AAAAAAA, 32'h05555555, 32'h0FFFFFFF, 32'h00123456};
        sel = 1'b1;
        @(negedge clk);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_word(words[i], 1'b0, ok, wr);
            checks++;
            if (ok !== 1'b1 || wr !== 1'b0) begin
                errors++;
                $display("FAIL full_word%0d: accepted=%b write_rdy=%b, want 1 0", i, ok, wr);
            end
        end
        @(negedge clk);
        checks++;
        if (full !== 1'b1 || rdy !== 1'b0 || wc_b !== 3'd4) begin
            errors++;
            $display("FAIL full_state: full=%b rdy=%b wc=%0d, want 1 0 4", full, rdy, wc_b);
        end
        byte_d = 8'h99;
        valid = 1'b1;
        repeat (3) @(negedge clk);
        valid = 1'b0;
        checks++;
        if (full !== 1'b1 || busy !== 1'b1 || wc_b !== 3'd4) begin
            errors++;
            $display("FAIL full_extra_byte: full=%b busy=%b wc=%0d, want 1 1 4", full, busy, wc_b);
        end
        en = 1'b0;
        @(negedge clk);
        checks++;
        if (full !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL full_exit: full=%b busy=%b, want 0 0", full, busy);
        end
        for (int i = 0; i < 4; i++) begin
            do_fetch(16'(i), d);
            checks++;
            if (d !== words[i][27:0]) begin
                errors++;
                $display("FAIL full_fetch%0d: got %h, want %h", i, d, words[i][27:0]);
            end
        end
        do_fetch(16'd4, d);
        checks++;
        if (d !== DEF_W) begin
            errors++;
            $display("FAIL full_range4: got %h, want %h", d, DEF_W);
        end
        sel = 1'b0;
    endtask

    initial begin
        test_reset;
        test_basic_load;
        test_gaps;
        test_abort;
        test_reset_midload;
        test_range;
        test_full;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
